// File: rtl/dm9000a_tx_pkg.sv
// rtl/dm9000a_tx_pkg.sv - shared types and constants for the DM9000A TX frame builders
package dm9000a_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int REQ_ETH     = 0;
    localparam int REQ_IP      = 1;
    localparam int REQ_UDP     = 2;
    localparam int REQ_PAYLOAD = 3;

    localparam int TIMEOUT_CYC_DEFAULT = 1023;

endpackage

// File: rtl/dpram_b_arbiter_rr_pick.sv
// rtl/dpram_b_arbiter_rr_pick.sv - combinational round-robin selector starting after the last grant
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = 3
) (
    input  logic [NREQ-1:0] iReq,
    input  logic [GW-1:0]   iLast,
    output logic [GW-1:0]   oSel,
    output logic            oValid
);

    // Scan from farthest to nearest so the nearest requester after iLast wins.
    always_comb begin
        oSel   = '0;
        oValid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(iLast) + k) % NREQ;
            if (|(iReq & (NREQ'(1) << idx))) begin
                oSel   = GW'(idx);
                oValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_b_arbiter.sv
// rtl/dpram_b_arbiter.sv - round-robin owner of DPRAM port B and the checksum engine; DPRAM_B_ARB_TIMEOUT_EN adds a grant watchdog
module dpram_b_arbiter
    import dm9000a_tx_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 10,
`ifdef DPRAM_B_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
`endif
    parameter int GW   = 3
) (
    input  logic               iDm9000aClk,
    input  logic               iRst,
    input  logic [NREQ-1:0]    iReq,
    output logic [NREQ-1:0]    oRunStart,
    input  logic [NREQ-1:0]    iRunEnd,
    input  logic [NREQ-1:0]    iReqWren,
    input  logic [NREQ*8-1:0]  iReqData,
    input  logic [NREQ*AW-1:0] iReqAddr,
    input  logic [NREQ-1:0]    iReqChkStart,
    input  logic [NREQ*16-1:0] iReqChkLen,
    input  logic [NREQ*AW-1:0] iReqChkAddr,
    output logic               wren_b,
    output logic [7:0]         data_b,
    output logic [AW-1:0]      address_b,
    output logic               oChkRunStart,
    output logic [15:0]        oChkLen,
    output logic [AW-1:0]      oChkStartAddr,
    input  logic               iChkRunEnd,
    input  logic [15:0]        iChkSum,
    output logic [NREQ-1:0]    oReqChkRunEnd,
    output logic [15:0]        oReqChkSum,
    output logic               oBusy,
`ifdef DPRAM_B_ARB_TIMEOUT_EN
    output logic               oTimeout,
`endif
    output logic [GW-1:0]      oGrantIdx
);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] run_q, run_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [GW-1:0]   pick_sel;
    logic            pick_valid;
    logic            run_end_g;
    logic [NREQ-1:0] grant_mask;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_rr_pick (
        .iReq   (iReq),
        .iLast  (last_q),
        .oSel   (pick_sel),
        .oValid (pick_valid)
    );

    assign grant_mask = NREQ'(1) << grant_q;
    assign run_end_g  = |(iRunEnd & grant_mask);

`ifdef DPRAM_B_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        expired;

    assign expired  = (cnt_q == 16'(TIMEOUT_CYC - 1));
    assign oTimeout = timeout_q;
`else
    logic expired;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef DPRAM_B_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    run_d   = NREQ'(1) << pick_sel;
                    grant_d = pick_sel;
                    last_d  = pick_sel;
`ifdef DPRAM_B_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
`ifdef DPRAM_B_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                if (run_end_g || expired) begin
                    state_d = ST_RELEASE;
                    run_d   = '0;
`ifdef DPRAM_B_ARB_TIMEOUT_EN
                    if (!run_end_g) timeout_d = 1'b1;
`endif
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iDm9000aClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            run_q     <= '0;
            grant_q   <= '0;
            last_q    <= GW'(NREQ - 1);
`ifdef DPRAM_B_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
`ifdef DPRAM_B_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Muxes follow the registered grant so async reset zeroes them without a clock edge.
    always_comb begin
        wren_b        = 1'b0;
        data_b        = '0;
        address_b     = '0;
        oChkRunStart  = 1'b0;
        oChkLen       = '0;
        oChkStartAddr = '0;
        oReqChkRunEnd = '0;
        if (state_q == ST_GRANT) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q == GW'(i)) begin
                    wren_b        = iReqWren[i];
                    data_b        = iReqData[i*8 +: 8];
                    address_b     = iReqAddr[i*AW +: AW];
                    oChkRunStart  = iReqChkStart[i];
                    oChkLen       = iReqChkLen[i*16 +: 16];
                    oChkStartAddr = iReqChkAddr[i*AW +: AW];
                end
            end
            oReqChkRunEnd = iChkRunEnd ? grant_mask : '0;
        end
    end

    assign oRunStart  = run_q;
    assign oReqChkSum = iChkSum;
    assign oBusy      = (state_q != ST_IDLE);
    assign oGrantIdx  = grant_q;

endmodule
